ampdrv_cfg_sched: RTL

AMPDRV_CFG_SCHED -- requirements
Module: ampdrv_cfg_sched

---
 rtl/ampdrv_cfg_sched.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ampdrv_cfg_sched.sv
// ampdrv_cfg_sched: shadow/active configuration scheduler for the amplifier driver.
// Writes land in a shadow bank at any time. A commit is applied only once the
// beam has been quiet for GUARD cycles, so active settings never move during a
// pulse or its settling tail.
//
// state    | meaning
// GAP_WAIT | store_strb low, counting quiet cycles toward GUARD
// SAFE     | quiet for at least GUARD cycles, a pending commit may be applied
// PULSE    | store_strb high, active outputs frozen
module ampdrv_cfg_sched #(
  parameter int unsigned GUARD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_strb,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        cfg_commit,
  input  logic        interleave_en,
  output logic [9:0]  start_proc,
  output logic [9:0]  end_proc,
  output logic [4:0]  Ldelay,
  output logic [1:0]  opMode,
  output logic [12:0] constDac_val,
  output logic [6:0]  IIRtapWeight,
  output logic        feedfwd_en,
  output logic        commit_ack,
  output logic        cfg_err,
  output logic        commit_pend,
  output logic [15:0] pulse_cnt
);

  typedef enum logic [1:0] {GAP_WAIT = 2'd0, SAFE = 2'd1, PULSE = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_guard_cnt, w_guard_nxt;
  logic        w_apply, w_valid, w_rise, w_fall;
  logic        r_strb_q, r_rise_seen, r_phase, r_pend, r_ack, r_err;
  logic [15:0] r_pulse_cnt;

  logic [9:0]  r_sh_start, r_sh_end, w_sh_start, w_sh_end;
  logic [4:0]  r_sh_ldly, w_sh_ldly;
  logic [1:0]  r_sh_op, r_sh_alt, w_sh_op, w_sh_alt;
  logic [12:0] r_sh_dac, w_sh_dac;
  logic [6:0]  r_sh_iir, w_sh_iir;
  logic        r_sh_ff, w_sh_ff;

  logic [9:0]  r_act_start, r_act_end;
  logic [4:0]  r_act_ldly;
  logic [1:0]  r_act_op, r_act_alt;
  logic [12:0] r_act_dac;
  logic [6:0]  r_act_iir;
  logic        r_act_ff;

  // Upper data bits have no destination register.
  logic w_unused;
  assign w_unused = ^cfg_data[15:13];

  // Shadow bank as it will be after this edge, so a copy sees a same-cycle write.
  always_comb begin
    w_sh_start = r_sh_start;
    w_sh_end   = r_sh_end;
    w_sh_ldly  = r_sh_ldly;
    w_sh_op    = r_sh_op;
    w_sh_dac   = r_sh_dac;
    w_sh_iir   = r_sh_iir;
    w_sh_alt   = r_sh_alt;
    w_sh_ff    = r_sh_ff;
    if (cfg_wr) begin
      case (cfg_addr)
        3'd0: w_sh_start = cfg_data[9:0];
        3'd1: w_sh_end   = cfg_data[9:0];
        3'd2: w_sh_ldly  = cfg_data[4:0];
        3'd3: w_sh_op    = cfg_data[1:0];
        3'd4: w_sh_dac   = cfg_data[12:0];
        3'd5: w_sh_iir   = cfg_data[6:0];
        3'd6: w_sh_alt   = cfg_data[1:0];
        3'd7: w_sh_ff    = cfg_data[0];
      endcase
    end
  end

  assign w_valid = (w_sh_end > w_sh_start);
  assign w_rise  = store_strb & ~r_strb_q;
  assign w_fall  = ~store_strb & r_strb_q;

  // Next-state, guard counting and apply decision.
  always_comb begin
    w_state_nxt = r_state;
    w_guard_nxt = r_guard_cnt;
    w_apply     = 1'b0;
    case (r_state)
      GAP_WAIT: begin
        if (store_strb) begin
          w_state_nxt = PULSE;
          w_guard_nxt = 8'd0;
        end else begin
          w_guard_nxt = r_guard_cnt + 8'd1;
          if (w_guard_nxt >= 8'(GUARD)) w_state_nxt = SAFE;
        end
      end
      SAFE: begin
        if (store_strb) begin
          w_state_nxt = PULSE;
          w_guard_nxt = 8'd0;
        end else if (r_pend) begin
          w_apply = 1'b1;
        end
      end
      PULSE: begin
        if (!store_strb) begin
          w_state_nxt = GAP_WAIT;
          w_guard_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt = GAP_WAIT;
        w_guard_nxt = 8'd0;
      end
    endcase
  end

  // State, guard counter, commit handshake and pulse bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= GAP_WAIT;
      r_guard_cnt <= 8'd0;
      r_pend      <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_strb_q    <= 1'b1;
      r_rise_seen <= 1'b0;
      r_phase     <= 1'b0;
      r_pulse_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_guard_cnt <= w_guard_nxt;
      r_pend      <= w_apply ? 1'b0 : (r_pend | cfg_commit);
      r_ack       <= w_apply & w_valid;
      r_err       <= w_apply & ~w_valid;
      r_strb_q    <= store_strb;
      if (w_rise) r_pulse_cnt <= r_pulse_cnt + 16'd1;
      // Only pulses whose rising edge was seen advance the interleave phase.
      if (w_rise) r_rise_seen <= 1'b1;
      else if (w_fall) r_rise_seen <= 1'b0;
      if (w_apply && w_valid) r_phase <= 1'b0;
      else if (w_fall && r_rise_seen) r_phase <= ~r_phase;
    end
  end

  // Shadow bank and active bank registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_start  <= 10'd0;
      r_sh_end    <= 10'd1023;
      r_sh_ldly   <= 5'd0;
      r_sh_op     <= 2'd0;
      r_sh_dac    <= 13'd0;
      r_sh_iir    <= 7'd0;
      r_sh_alt    <= 2'd0;
      r_sh_ff     <= 1'b0;
      r_act_start <= 10'd0;
      r_act_end   <= 10'd1023;
      r_act_ldly  <= 5'd0;
      r_act_op    <= 2'd0;
      r_act_dac   <= 13'd0;
      r_act_iir   <= 7'd0;
      r_act_alt   <= 2'd0;
      r_act_ff    <= 1'b0;
    end else begin
      r_sh_start <= w_sh_start;
      r_sh_end   <= w_sh_end;
      r_sh_ldly  <= w_sh_ldly;
      r_sh_op    <= w_sh_op;
      r_sh_dac   <= w_sh_dac;
      r_sh_iir   <= w_sh_iir;
      r_sh_alt   <= w_sh_alt;
      r_sh_ff    <= w_sh_ff;
      if (w_apply && w_valid) begin
        r_act_start <= w_sh_start;
        r_act_end   <= w_sh_end;
        r_act_ldly  <= w_sh_ldly;
        r_act_op    <= w_sh_op;
        r_act_dac   <= w_sh_dac;
        r_act_iir   <= w_sh_iir;
        r_act_alt   <= w_sh_alt;
        r_act_ff    <= w_sh_ff;
      end
    end
  end

  assign start_proc   = r_act_start;
  assign end_proc     = r_act_end;
  assign Ldelay       = r_act_ldly;
  assign opMode       = (interleave_en && r_phase) ? r_act_alt : r_act_op;
  assign constDac_val = r_act_dac;
  assign IIRtapWeight = r_act_iir;
  assign feedfwd_en   = r_act_ff;
  assign commit_ack   = r_ack;
  assign cfg_err      = r_err;
  assign commit_pend  = r_pend;
  assign pulse_cnt    = r_pulse_cnt;

endmodule
